// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psum_pkg
// Description : Shared types and constants for the partial-sum buffer
//               controller: FSM state encoding and adder-pipeline gap length.
// Revision    : 1.0 - initial release
// ============================================================================
package psum_pkg;

    // Controller states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_GAP   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } psum_state_t;

    // Idle cycles between rows so the adder pipeline can empty
    localparam int GAP_CYCLES = 3;

endpackage
`default_nettype wire

// File: rtl/psum_wrap_cnt.sv
`default_nettype none
// ============================================================================
// Module      : psum_wrap_cnt
// Description : Enable/clear up-counter that wraps from MAX-1 back to zero.
//               o_wrap flags the enabled cycle on which the wrap happens.
// Revision    : 1.0 - initial release
// ============================================================================
module psum_wrap_cnt #(
    parameter int MAX   = 4,
    parameter int WIDTH = (MAX > 1) ? $clog2(MAX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_top = WIDTH'(MAX - 1);

    logic [WIDTH-1:0] r_count;

    assign o_count = r_count;
    assign o_wrap  = i_en && (r_count == c_top);

    // Count enabled cycles, returning to zero after the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (r_count == c_top) ? '0 : r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : psum_ctrl
// Description : Partial-sum buffer controller. Zero-fills the psum FIFOs,
//               accumulates PASSES passes of DEPTH PE columns per output row,
//               inserts an adder-pipeline gap between rows and drains the
//               last row. Optional macro PSUM_CTRL_PERF_EN adds a saturating
//               stall-cycle counter output (perf_stall).
// Revision    : 1.0 - initial release
// ============================================================================
module psum_ctrl
    import psum_pkg::*;
#(
    parameter int DEPTH  = 61,
    parameter int PASSES = 3,
    parameter int ROW_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ROW_W-1:0] cfg_rows,
    output logic             busy,
    output logic             done,
    input  logic             pe_valid,
    output logic             pe_ready,
    output logic             p_init,
    output logic             p_valid_data,
    output logic             p_write_zero,
    output logic             odd_cnt,
    output logic [ROW_W-1:0] row_idx
`ifdef PSUM_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall
`endif
);

    localparam int c_col_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_pass_w = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int c_gap_w  = $clog2(GAP_CYCLES);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

    psum_state_t        r_state;
    psum_state_t        w_next;
    logic [ROW_W-1:0]   r_rows;
    logic [ROW_W-1:0]   r_row_idx;
    logic [ROW_W-1:0]   w_row_inc;
    logic               r_odd;
    logic [c_gap_w-1:0] r_gap;
    logic               w_start_acc;
    logic               w_xfer;
    logic               w_col_en;
    logic               w_col_wrap;
    logic               w_pass_en;
    logic               w_pass_wrap;
    logic               w_row_adv;
    logic [c_pass_w-1:0] w_pass_cnt;
    // Column position itself is not needed outside the counter
    logic [c_col_w-1:0]  w_unused_col_cnt;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_xfer      = (r_state == ST_ACCUM) && pe_valid;
    // The column counter also times the DEPTH-cycle INIT and DRAIN phases
    assign w_col_en    = (r_state == ST_INIT) || (r_state == ST_DRAIN) || w_xfer;
    assign w_pass_en   = (r_state == ST_ACCUM) && w_col_wrap;
    assign w_row_inc   = r_row_idx + 1'b1;
    assign busy        = (r_state != ST_IDLE);
    assign odd_cnt     = r_odd;
    assign row_idx     = r_row_idx;

    psum_wrap_cnt #(
        .MAX   (DEPTH),
        .WIDTH (c_col_w)
    ) u_col_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_acc),
        .i_en    (w_col_en),
        .o_count (w_unused_col_cnt),
        .o_wrap  (w_col_wrap)
    );

    psum_wrap_cnt #(
        .MAX   (PASSES),
        .WIDTH (c_pass_w)
    ) u_pass_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_acc),
        .i_en    (w_pass_en),
        .o_count (w_pass_cnt),
        .o_wrap  (w_pass_wrap)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Job row count, current row index and FIFO ping-pong select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows    <= '0;
            r_row_idx <= '0;
            r_odd     <= 1'b0;
        end else if (w_start_acc) begin
            r_rows    <= cfg_rows;
            r_row_idx <= '0;
            r_odd     <= 1'b0;
        end else if (w_row_adv) begin
            r_row_idx <= w_row_inc;
            r_odd     <= ~r_odd;
        end
    end

    // Gap cycle counter, idle at zero outside GAP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= '0;
        end else if (r_state == ST_GAP) begin
            r_gap <= (r_gap == c_gap_last) ? '0 : r_gap + 1'b1;
        end else begin
            r_gap <= '0;
        end
    end

    // Next-state decode and per-state buffer control outputs
    always_comb begin
        w_next       = r_state;
        pe_ready     = 1'b0;
        p_init       = 1'b0;
        p_valid_data = 1'b0;
        p_write_zero = 1'b0;
        done         = 1'b0;
        w_row_adv    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (cfg_rows == '0) ? ST_DONE : ST_INIT;
                end
            end
            ST_INIT: begin
                p_init = 1'b1;
                if (w_col_wrap) begin
                    w_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                pe_ready     = 1'b1;
                p_valid_data = pe_valid;
                // First pass of every row after row 0 recycles the finished row's FIFO
                p_write_zero = pe_valid && (w_pass_cnt == '0) && (r_row_idx != '0);
                if (w_pass_wrap) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_row_adv = 1'b1;
                    w_next    = (w_row_inc == r_rows) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                p_write_zero = 1'b1;
                if (w_col_wrap) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

`ifdef PSUM_CTRL_PERF_EN
    logic [31:0] r_perf_stall;

    assign perf_stall = r_perf_stall;

    // Saturating count of ACCUM cycles with no PE column offered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall <= '0;
        end else if (w_start_acc) begin
            r_perf_stall <= '0;
        end else if ((r_state == ST_ACCUM) && !pe_valid && (r_perf_stall != '1)) begin
            r_perf_stall <= r_perf_stall + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/psum_ctrl.md
PSUM_CTRL -- requirements
Module: psum_ctrl

Interface
REQ-001 Parameter DEPTH, default 61: psum columns per output row; equals the partial-sum buffer FIFO depth.
REQ-002 Parameter PASSES, default 3: accumulation passes (kernel rows) per output row.
REQ-003 Parameter ROW_W, default 8: width of the row count and row index.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle job request; sampled only in IDLE.
REQ-007 cfg_rows  input  ROW_W  number of output rows in the job; latched on accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse at job end.
REQ-010 pe_valid  input  1  PE array presents one column of three PE results.
REQ-011 pe_ready  output  1  controller accepts a column; transfer = pe_valid & pe_ready.
REQ-012 p_init  output  1  zero-fill both psum FIFOs.
REQ-013 p_valid_data  output  1  current PE column is valid for accumulation.
REQ-014 p_write_zero  output  1  read out the finished row's FIFO and rewrite it with zero.
REQ-015 odd_cnt  output  1  FIFO ping-pong select; toggles once per output row.
REQ-016 row_idx  output  ROW_W  index of the output row being accumulated.

Function
REQ-017 States: IDLE, INIT, ACCUM, GAP, DRAIN, DONE; next-state and counters register on clk.
REQ-018 IDLE: pe_ready=0; start=1 latches cfg_rows and clears row, pass, column and gap counters; next state INIT; start is ignored in all other states.
REQ-019 start with cfg_rows=0: IDLE->DONE directly; INIT, ACCUM and DRAIN are skipped.
REQ-020 INIT: p_init=1 for exactly DEPTH cycles, then ACCUM; pe_ready=0.
REQ-021 ACCUM: pe_ready=1; p_valid_data = pe_valid & pe_ready, combinational, zero added latency.
REQ-022 ACCUM: the column counter increments per transfer and wraps at DEPTH-1; each wrap increments the pass counter; the wrap ending pass PASSES-1 moves to GAP.
REQ-023 ACCUM: p_write_zero = transfer during pass 0 of rows with row_idx>=1; otherwise 0.
REQ-024 pe_valid=0 in ACCUM stalls all counters; no output pulses.
REQ-025 GAP: pe_ready=0 for exactly 3 cycles to match the adder pipeline; on the last GAP cycle odd_cnt toggles and row_idx increments; next state DRAIN if the new row_idx equals cfg_rows, else ACCUM.
REQ-026 DRAIN: p_write_zero=1 for DEPTH cycles with p_valid_data=0; then DONE.
REQ-027 DONE: done=1 for one cycle; next state IDLE; row_idx holds until the next start.
REQ-028 p_init, p_valid_data and p_write_zero are never high in IDLE, GAP or DONE; p_init never coincides with the other two.

Reset
REQ-029 rst_n low, including mid-job, forces IDLE immediately; busy, done, pe_ready, p_init, p_valid_data, p_write_zero, odd_cnt and row_idx all read 0 and counters clear.

Configuration
REQ-030 Macro PSUM_CTRL_PERF_EN defined: adds output perf_stall  output  32  count of ACCUM cycles with pe_valid=0; clears on accepted start; saturates at all-ones.
REQ-031 PSUM_CTRL_PERF_EN undefined: port and counter absent; all other behaviour is identical.

Structure
REQ-032 Shared package psum_pkg holds the state enumeration and the constant GAP_CYCLES=3.
REQ-033 One sub-module, psum_wrap_cnt: a parameterised enable/clear up-counter with wrap flag, instanced for the column and pass counters.

Verification
REQ-034 DEPTH=4, PASSES=3, cfg_rows=2, pe_valid always 1, start at cycle 0 -> p_init cycles 1-4, ACCUM 5-16, GAP 17-19, ACCUM 20-31, GAP 32-34, DRAIN 35-38, done at 39.
REQ-035 Same job -> p_write_zero high on cycles 20-23 and 35-38 only; odd_cnt toggles at cycles 20 and 35.
REQ-036 pe_valid low every other cycle in ACCUM -> p_valid_data count per row = 12; total job length grows by exactly 12 cycles per row.
REQ-037 start with cfg_rows=0 -> done at cycle 1; p_init, p_valid_data and p_write_zero never asserted.
REQ-038 rst_n low at cycle 10 of the REQ-034 job, released at 12, start at 13 -> all outputs 0 during reset; new job timing equals REQ-034 offset by 13 cycles.
REQ-039 With PSUM_CTRL_PERF_EN, REQ-036 stimulus -> perf_stall = 24 at done.
